// File: rtl/key_filter_if.sv
// rtl/key_filter_if.sv - key pin and debounced event bundle for key_filter
//
// Signals:
//   key_in      raw key pins, active-low, asynchronous to clk
//   key_state   debounced level per key, 1 = pressed
//   key_press   one-cycle pulse per debounced press
//   key_release one-cycle pulse per debounced release
//   key_long    one-cycle pulse once a press has been held long enough
// Modports:
//   master      board side: drives key_in, consumes the events
//   slave       filter side: samples key_in, produces the events
interface key_filter_if #(
    parameter int KEY_W = 4
);
    logic [KEY_W-1:0] key_in;
    logic [KEY_W-1:0] key_state;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;
    logic [KEY_W-1:0] key_long;

    modport master (
        output key_in,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_in,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_filter.sv
// rtl/key_filter.sv - per-key synchronizer, debounce FSM and press/release/long pulses
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   kif    key_filter_if slave: key_in in, key_state/key_press/key_release/key_long out
// Each key owns a 2-FF synchronizer, a four-state debounce FSM, a debounce
// counter (dcnt) and a saturating long-press counter (lcnt). All outputs are
// registered.
module key_filter #(
    parameter int          KEY_W    = 4,
    parameter logic [19:0] CNT_DBNC = 20'd999_999,
    parameter logic [25:0] CNT_LONG = 26'd49_999_999
) (
    input  logic         clk,
    input  logic         rst_n,
    key_filter_if.slave  kif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_FLT = 2'd1,
        HELD      = 2'd2,
        REL_FLT   = 2'd3
    } state_t;

    logic [KEY_W-1:0] state_v;
    logic [KEY_W-1:0] press_v;
    logic [KEY_W-1:0] rel_v;
    logic [KEY_W-1:0] long_v;

    for (genvar k = 0; k < KEY_W; k++) begin : g_key
        logic        s1;
        logic        s2;
        state_t      state;
        state_t      state_nxt;
        logic [19:0] dcnt;
        logic [19:0] dcnt_nxt;
        logic [25:0] lcnt;
        logic [25:0] lcnt_nxt;
        // Set once key_long has fired for the current press so that a
        // saturated lcnt does not re-trigger after a REL_FLT excursion.
        logic        long_done;
        logic        long_done_nxt;
        logic        level_q;
        logic        press_q;
        logic        rel_q;
        logic        long_q;
        logic        level_nxt;
        logic        press_nxt;
        logic        rel_nxt;
        logic        long_nxt;

        // Synchronizer idles at 1 (released) so a key held through reset
        // shows up as a fresh falling edge after deassertion.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1 <= 1'b1;
                s2 <= 1'b1;
            end else begin
                s1 <= kif.key_in[k];
                s2 <= s1;
            end
        end

        // State register plus registered outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                dcnt      <= '0;
                lcnt      <= '0;
                long_done <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                rel_q     <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state     <= state_nxt;
                dcnt      <= dcnt_nxt;
                lcnt      <= lcnt_nxt;
                long_done <= long_done_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                rel_q     <= rel_nxt;
                long_q    <= long_nxt;
            end
        end

        // Next-state and counter logic.
        always_comb begin
            state_nxt     = state;
            dcnt_nxt      = dcnt;
            lcnt_nxt      = lcnt;
            long_done_nxt = long_done;
            if (long_nxt) begin
                long_done_nxt = 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!s2) begin
                        state_nxt = PRESS_FLT;
                        dcnt_nxt  = '0;
                    end
                end
                PRESS_FLT: begin
                    if (s2) begin
                        state_nxt = IDLE;
                        dcnt_nxt  = '0;
                    end else if (dcnt == CNT_DBNC) begin
                        state_nxt     = HELD;
                        dcnt_nxt      = '0;
                        lcnt_nxt      = '0;
                        long_done_nxt = 1'b0;
                    end else begin
                        dcnt_nxt = dcnt + 20'd1;
                    end
                end
                HELD: begin
                    if (s2) begin
                        state_nxt = REL_FLT;
                        dcnt_nxt  = '0;
                    end else if (lcnt != CNT_LONG) begin
                        lcnt_nxt = lcnt + 26'd1;
                    end
                end
                REL_FLT: begin
                    // lcnt is frozen here; a low glitch resumes HELD with it intact.
                    if (!s2) begin
                        state_nxt = HELD;
                        dcnt_nxt  = '0;
                    end else if (dcnt == CNT_DBNC) begin
                        state_nxt     = IDLE;
                        dcnt_nxt      = '0;
                        lcnt_nxt      = '0;
                        long_done_nxt = 1'b0;
                    end else begin
                        dcnt_nxt = dcnt + 20'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    dcnt_nxt  = '0;
                    lcnt_nxt  = '0;
                end
            endcase
        end

        // Output decode, registered by the state process.
        always_comb begin
            press_nxt = (state == PRESS_FLT) && !s2 && (dcnt == CNT_DBNC);
            rel_nxt   = (state == REL_FLT) && s2 && (dcnt == CNT_DBNC);
            // Fires in the first cycle lcnt is seen saturated; only one shot per press.
            long_nxt  = ((state == HELD) || (state == REL_FLT)) &&
                        (lcnt == CNT_LONG) && !long_done;
            level_nxt = level_q;
            if (press_nxt) begin
                level_nxt = 1'b1;
            end else if (rel_nxt) begin
                level_nxt = 1'b0;
            end
        end

        assign state_v[k] = level_q;
        assign press_v[k] = press_q;
        assign rel_v[k]   = rel_q;
        assign long_v[k]  = long_q;
    end

    assign kif.key_state   = state_v;
    assign kif.key_press   = press_v;
    assign kif.key_release = rel_v;
    assign kif.key_long    = long_v;

endmodule

// File: tb/tb_key_filter.sv
// tb/tb_key_filter.sv - scoreboard bench for key_filter
module tb_key_filter;

    localparam int          KEY_W    = 4;
    localparam logic [19:0] CNT_DBNC = 20'd3;
    localparam logic [25:0] CNT_LONG = 26'd20;
    // Cycles from driving a clean level at a negedge to seeing the pulse at a later negedge.
    localparam int LAT    = int'(CNT_DBNC) + 4;
    // Cycles from key_press to key_long.
    localparam int LONG_D = int'(CNT_LONG) + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    key_filter_if #(.KEY_W(KEY_W)) kif ();

    key_filter #(
        .KEY_W    (KEY_W),
        .CNT_DBNC (CNT_DBNC),
        .CNT_LONG (CNT_LONG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    typedef struct {
        int       cyc;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] l;
    } evt_t;

    evt_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Insert sorted by cycle; events landing on the same cycle merge into one entry.
    function automatic void push_evt(input int ec, input logic [3:0] p,
                                     input logic [3:0] r, input logic [3:0] l);
        evt_t e;
        e.cyc = ec;
        e.p   = p;
        e.r   = r;
        e.l   = l;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc == ec) begin
                exp_q[i].p = exp_q[i].p | p;
                exp_q[i].r = exp_q[i].r | r;
                exp_q[i].l = exp_q[i].l | l;
                return;
            end
            if (exp_q[i].cyc > ec) begin
                exp_q.insert(i, e);
                return;
            end
        end
        exp_q.push_back(e);
    endfunction

    // Monitor: every pulse must match the head of the queue in the right cycle.
    always @(negedge clk) begin
        evt_t e;
        logic [11:0] got;
        if (rst_n === 1'b1) begin
            got = {kif.key_press, kif.key_release, kif.key_long};
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("missed_evt", 32'(0), 32'({e.p, e.r, e.l}));
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("evt_press_rel_long", 32'(got), 32'({e.p, e.r, e.l}));
            end else if (got != 12'h0) begin
                check("unexpected_evt", 32'(got), 32'(0));
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_state"},   32'(kif.key_state),   32'(0));
        check({tag, "_press"},   32'(kif.key_press),   32'(0));
        check({tag, "_release"}, 32'(kif.key_release), 32'(0));
        check({tag, "_long"},    32'(kif.key_long),    32'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        kif.key_in = 4'hF;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_state", 32'(kif.key_state), 32'(0));

        // Clean press on key 0.
        kif.key_in[0] = 1'b0;
        push_evt(cyc + LAT, 4'b0001, 4'b0000, 4'b0000);
        push_evt(cyc + LAT + LONG_D, 4'b0000, 4'b0000, 4'b0001);
        repeat (10) @(negedge clk);
        check("state_k0", 32'(kif.key_state), 32'(4'b0001));

        // Key 1: 3 low cycles, 1 high, then steady low.
        kif.key_in[1] = 1'b0;
        repeat (3) @(negedge clk);
        kif.key_in[1] = 1'b1;
        @(negedge clk);
        kif.key_in[1] = 1'b0;
        push_evt(cyc + LAT, 4'b0010, 4'b0000, 4'b0000);
        push_evt(cyc + LAT + LONG_D, 4'b0000, 4'b0000, 4'b0010);
        repeat (10) @(negedge clk);
        check("state_k1", 32'(kif.key_state), 32'(4'b0011));

        // Key 2 held 30 cycles past its press pulse.
        kif.key_in[2] = 1'b0;
        push_evt(cyc + LAT, 4'b0100, 4'b0000, 4'b0000);
        push_evt(cyc + LAT + LONG_D, 4'b0000, 4'b0000, 4'b0100);
        repeat (LAT + 30) @(negedge clk);
        check("state_k2", 32'(kif.key_state), 32'(4'b0111));

        // Release key 0 with a 2-cycle low glitch inside REL_FLT.
        kif.key_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        kif.key_in[0] = 1'b0;
        repeat (2) @(negedge clk);
        kif.key_in[0] = 1'b1;
        push_evt(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
        repeat (10) @(negedge clk);
        check("state_k0_rel", 32'(kif.key_state), 32'(4'b0110));

        // Keys 0 and 3 together.
        kif.key_in[0] = 1'b0;
        kif.key_in[3] = 1'b0;
        push_evt(cyc + LAT, 4'b1001, 4'b0000, 4'b0000);
        push_evt(cyc + LAT + LONG_D, 4'b0000, 4'b0000, 4'b1001);
        repeat (32) @(negedge clk);
        check("state_all", 32'(kif.key_state), 32'(4'b1111));
        check("queue_before_reset", 32'(exp_q.size()), 32'(0));

        // Reset mid-press: outputs drop without clock, no release afterwards.
        rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        kif.key_in = 4'b1101;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_evt(cyc + LAT, 4'b0010, 4'b0000, 4'b0000);
        push_evt(cyc + LAT + LONG_D, 4'b0000, 4'b0000, 4'b0010);
        #1 check("state_after_reset", 32'(kif.key_state), 32'(0));
        repeat (35) @(negedge clk);
        check("state_k1_again", 32'(kif.key_state), 32'(4'b0010));

        kif.key_in[1] = 1'b1;
        push_evt(cyc + LAT, 4'b0000, 4'b0010, 4'b0000);
        repeat (10) @(negedge clk);
        check("state_final", 32'(kif.key_state), 32'(0));
        check("queue_final", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
